// File: rtl/div_ctrl_pkg.sv
// Shared constants, state encoding and helpers for the multi-cycle divide controller.
package div_ctrl_pkg;

   localparam int DATA_W     = 32;
   localparam int DIV_CYCLES = DATA_W;
   localparam int CNT_W      = $clog2(DIV_CYCLES);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic logic [DATA_W-1:0] cond_neg(input logic neg, input logic [DATA_W-1:0] v);
      return neg ? -v : v;
   endfunction

endpackage

// File: rtl/div_ctrl_core.sv
// Iterative restoring shift-subtract datapath: one quotient bit per step.
module div_core
   import div_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              preset,
   input  logic              step,
   input  logic [DATA_W-1:0] dividend,
   input  logic [DATA_W-1:0] divisor_in,
   output logic              last_step,
   output logic [DATA_W-1:0] rem,
   output logic [DATA_W-1:0] quo
);

   logic [DATA_W-1:0] divisor;
   logic [CNT_W-1:0]  count;
   logic [DATA_W:0]   trial;

   // Partial remainder stays below the divisor, so the shifted value fits in DATA_W+1 bits.
   assign trial     = {rem, quo[DATA_W-1]} - {1'b0, divisor};
   assign last_step = (count == CNT_W'(DIV_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         rem     <= '0;
         quo     <= '0;
         divisor <= '0;
         count   <= '0;
      end else if (load) begin
         rem     <= '0;
         quo     <= dividend;
         divisor <= divisor_in;
         count   <= '0;
      end else if (preset) begin
         rem     <= dividend;
         quo     <= '1;
         divisor <= divisor_in;
         count   <= '0;
      end else if (step) begin
         if (!trial[DATA_W]) begin
            rem <= trial[DATA_W-1:0];
            quo <= {quo[DATA_W-2:0], 1'b1};
         end else begin
            rem <= {rem[DATA_W-2:0], quo[DATA_W-1]};
            quo <= {quo[DATA_W-2:0], 1'b0};
         end
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/div_ctrl.sv
// DIV/DIVU sequencer for the EX stage: stalls the pipe, runs div_core, writes HI/LO once.
//
// state | meaning
// IDLE  | waiting for op_valid; latches operands and sign flags
// RUN   | one restoring step per cycle, DATA_W steps total
// DONE  | apply signs, pulse hilo_we, release the stall
module div_ctrl
   import div_ctrl_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                op_valid,
   input  logic                op_signed,
   input  logic [DATA_W-1:0]   opa,
   input  logic [DATA_W-1:0]   opb,
   input  logic                flush,
   output logic                stall_o,
   output logic                busy,
   output logic                hilo_we,
   output logic [2*DATA_W-1:0] hilo_o
);

   state_t              state, state_nxt;
   logic                start_div, start_zero, core_step, last_step;
   logic                q_neg, r_neg;
   logic [DATA_W-1:0]   dividend, divisor_in, rem, quo;
   logic [2*DATA_W-1:0] result, hilo_q;

   // A zero divisor passes opa through untouched so the remainder reads back as opa.
   assign dividend   = (opb == '0) ? opa : cond_neg(op_signed & opa[DATA_W-1], opa);
   assign divisor_in = cond_neg(op_signed & opb[DATA_W-1], opb);

   div_core u_core (
      .clk        (clk),
      .rst        (rst),
      .load       (start_div),
      .preset     (start_zero),
      .step       (core_step),
      .dividend   (dividend),
      .divisor_in (divisor_in),
      .last_step  (last_step),
      .rem        (rem),
      .quo        (quo)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      start_div  = 1'b0;
      start_zero = 1'b0;
      core_step  = 1'b0;
      hilo_we    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (op_valid && !flush) begin
               if (opb != '0) begin
                  start_div = 1'b1;
                  state_nxt = ST_RUN;
               end else begin
                  start_zero = 1'b1;
                  state_nxt  = ST_DONE;
               end
            end
         end
         ST_RUN: begin
            core_step = 1'b1;
            if (last_step) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            hilo_we   = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
      if (flush) begin
         state_nxt = ST_IDLE;
         core_step = 1'b0;
         hilo_we   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_neg <= 1'b0;
         r_neg <= 1'b0;
      end else if (start_div) begin
         q_neg <= op_signed & (opa[DATA_W-1] ^ opb[DATA_W-1]);
         r_neg <= op_signed & opa[DATA_W-1];
      end else if (start_zero) begin
         q_neg <= 1'b0;
         r_neg <= 1'b0;
      end
   end

   assign result = {cond_neg(r_neg, rem), cond_neg(q_neg, quo)};

   always_ff @(posedge clk) begin
      if (rst) begin
         hilo_q <= '0;
      end else if (hilo_we) begin
         hilo_q <= result;
      end
   end

   assign hilo_o  = (state == ST_DONE) ? result : hilo_q;
   assign busy    = (state != ST_IDLE);
   assign stall_o = op_valid & !flush & (state != ST_DONE);

endmodule

// File: tb/tb_div_ctrl.sv
// Directed plus randomized checks of div_ctrl against an arithmetic reference model.
module tb_div_ctrl;
   import div_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst, op_valid, op_signed, flush;
   logic [31:0] opa, opb;
   logic        stall_o, busy, hilo_we;
   logic [63:0] hilo_o;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   div_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .op_valid  (op_valid),
      .op_signed (op_signed),
      .opa       (opa),
      .opb       (opb),
      .flush     (flush),
      .stall_o   (stall_o),
      .busy      (busy),
      .hilo_we   (hilo_we),
      .hilo_o    (hilo_o)
   );

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      if (b == 32'd0) return {a, 32'hFFFF_FFFF};
      if (s) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         q  = sa / sb;
         r  = sa % sb;
         return {r[31:0], q[31:0]};
      end
      return {a % b, a / b};
   endfunction

   task automatic do_div(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b);
      int          stalls = 0;
      int          lat    = -1;
      int          cyc    = 0;
      int          exp_lat;
      logic [63:0] res    = '0;
      @(posedge clk); #1;
      op_valid = 1'b1; op_signed = s; opa = a; opb = b;
      while (cyc < 80) begin
         @(negedge clk);
         if (stall_o) stalls++;
         if (hilo_we) begin
            lat = cyc;
            res = hilo_o;
            break;
         end
         @(posedge clk); #1;
         cyc++;
      end
      @(posedge clk); #1;
      op_valid = 1'b0;
      exp_lat = (b == 32'd0) ? 1 : DIV_CYCLES + 1;
      chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
      chk({tag, " stalls"}, 64'(stalls), 64'(exp_lat));
      chk({tag, " hilo"}, res, ref_div(s, a, b));
      @(negedge clk);
      chk({tag, " quiet"}, 64'({busy, hilo_we, stall_o}), 64'd0);
   endtask

   initial begin
      int          we_seen, t1, t2;
      logic [63:0] r1, r2;
      rst = 1'b1; op_valid = 1'b0; op_signed = 1'b0; flush = 1'b0; opa = '0; opb = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset outputs", {busy, hilo_we, stall_o, hilo_o[60:0]}, 64'd0);

      do_div("divu 100/7", 1'b0, 32'd100, 32'd7);
      do_div("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2);
      do_div("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE);
      do_div("div ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
      do_div("divu ovf", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
      do_div("divu 5/0", 1'b0, 32'd5, 32'd0);
      do_div("div -5/0", 1'b1, 32'hFFFF_FFFB, 32'd0);

      // flush in RUN cycle 10
      @(posedge clk); #1;
      op_valid = 1'b1; op_signed = 1'b0; opa = 32'hDEAD_BEEF; opb = 32'h13;
      repeat (10) begin @(posedge clk); #1; end
      flush = 1'b1;
      @(negedge clk);
      chk("flush stall", 64'(stall_o), 64'd0);
      @(posedge clk); #1;
      flush = 1'b0; op_valid = 1'b0;
      @(negedge clk);
      chk("flush idle", 64'({busy, hilo_we, stall_o}), 64'd0);
      we_seen = 0;
      repeat (40) begin @(negedge clk); if (hilo_we) we_seen++; end
      chk("flush no we", 64'(we_seen), 64'd0);
      do_div("after flush 9/3", 1'b0, 32'd9, 32'd3);

      // flush coinciding with DONE
      @(posedge clk); #1;
      op_valid = 1'b1; op_signed = 1'b0; opa = 32'd5; opb = 32'd0;
      @(posedge clk); #1;
      flush = 1'b1;
      @(negedge clk);
      chk("flush in done we", 64'(hilo_we), 64'd0);
      @(posedge clk); #1;
      flush = 1'b0; op_valid = 1'b0;

      // reset in RUN cycle 20
      @(posedge clk); #1;
      op_valid = 1'b1; op_signed = 1'b1; opa = 32'd1000; opb = 32'd7;
      repeat (20) begin @(posedge clk); #1; end
      rst = 1'b1; op_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("reset mid run", {busy, hilo_we, stall_o, hilo_o[60:0]}, 64'd0);
      we_seen = 0;
      repeat (40) begin @(negedge clk); if (hilo_we) we_seen++; end
      chk("reset no we", 64'(we_seen), 64'd0);

      // back-to-back operations
      t1 = -1; t2 = -1; r1 = '0; r2 = '0;
      @(posedge clk); #1;
      op_valid = 1'b1; op_signed = 1'b1; opa = 32'hFFFF_FF9C; opb = 32'd7;
      for (int cyc = 0; cyc < 150; cyc++) begin
         @(negedge clk);
         if (hilo_we) begin
            if (t1 < 0) begin
               t1 = cyc; r1 = hilo_o;
            end else begin
               t2 = cyc; r2 = hilo_o;
               break;
            end
         end
         @(posedge clk); #1;
         if (t1 == cyc) begin
            op_signed = 1'b0; opa = 32'd12345; opb = 32'h10;
         end
      end
      @(posedge clk); #1;
      op_valid = 1'b0;
      chk("b2b first", r1, ref_div(1'b1, 32'hFFFF_FF9C, 32'd7));
      chk("b2b second", r2, ref_div(1'b0, 32'd12345, 32'h10));
      chk("b2b spacing", 64'(t2 - t1), 64'd34);

      for (int i = 0; i < 24; i++) begin
         logic        s;
         logic [31:0] a, b;
         s = 1'($urandom_range(0, 1));
         a = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
         case ($urandom_range(0, 7))
            0:       b = 32'd0;
            1:       b = 32'($urandom_range(1, 15));
            2:       b = 32'hFFFF_FFFF;
            default: b = $urandom;
         endcase
         do_div($sformatf("rand%0d", i), s, a, b);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
